// File: rtl/riscv151_core.sv
// riscv151_core: multi-cycle RV32I CPU executing from a 16 KB BIOS RAM.
// Each instruction walks FETCH -> EXEC, with loads taking an extra MEM cycle.

module riscv151_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] registers [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= 32'd0;
      end
    end else if (we && wa != 5'd0) begin
      registers[wa] <= wd;
    end
  end
endmodule

module riscv151_bios #(
  parameter integer AWIDTH = 12
) (
  input  logic              clk,
  input  logic              ena,
  input  logic [AWIDTH-1:0] addra,
  output logic [31:0]       douta,
  input  logic              enb,
  input  logic [3:0]        web,
  input  logic [AWIDTH-1:0] addrb,
  input  logic [31:0]       dinb,
  output logic [31:0]       doutb
);
  logic [31:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (ena) begin
      douta <= mem[addra];
    end
  end

  always_ff @(posedge clk) begin
    if (enb) begin
      doutb <= mem[addrb];
      for (int i = 0; i < 4; i++) begin
        if (web[i]) begin
          mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
        end
      end
    end
  end
endmodule

module riscv151_core #(
  parameter integer      CPU_CLOCK_FREQ = 50_000_000,
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter integer      BIOS_AWIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic FPGA_SERIAL_RX,
  output logic FPGA_SERIAL_TX
);
  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_4;
  logic [31:0] inst, rv1, rv2, doutb;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] imm_u, imm_j;
  logic        is_lui, is_auipc, is_jal;
  logic        is_jalr, is_br, is_ld;
  logic        is_st, is_opi, is_op;
  logic [31:0] alu_b, alu_y, sra_y;
  logic [4:0]  shamt;
  logic        sub, taken;
  logic [31:0] addr, next_pc;
  logic        hit;
  logic [3:0]  st_be, web;
  logic [31:0] st_d;
  logic        ena, enb;
  logic        exec_we, rf_we;
  logic [31:0] exec_wd, rf_wd;
  logic [1:0]  ld_lo;
  logic        ld_hit;
  logic [31:0] ld_w, ld_val;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        unused;

  assign FPGA_SERIAL_TX = 1'b1;
  assign unused = &{1'b0, FPGA_SERIAL_RX,
                    CPU_CLOCK_FREQ[0],
                    addr[27:BIOS_AWIDTH+2]};

  riscv151_regfile rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rv1),
    .rd2 (rv2),
    .we  (rf_we),
    .wa  (rd),
    .wd  (rf_wd)
  );

  riscv151_bios #(
    .AWIDTH (BIOS_AWIDTH)
  ) bios_mem (
    .clk   (clk),
    .ena   (ena),
    .addra (pc[BIOS_AWIDTH+1:2]),
    .douta (inst),
    .enb   (enb),
    .web   (web),
    .addrb (addr[BIOS_AWIDTH+1:2]),
    .dinb  (st_d),
    .doutb (doutb)
  );

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25],
                  inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31],
                  inst[19:12], inst[20],
                  inst[30:21], 1'b0};

  assign is_lui   = opcode == 7'h37;
  assign is_auipc = opcode == 7'h17;
  assign is_jal   = opcode == 7'h6f;
  assign is_jalr  = opcode == 7'h67;
  assign is_br    = opcode == 7'h63;
  assign is_ld    = opcode == 7'h03;
  assign is_st    = opcode == 7'h23;
  assign is_opi   = opcode == 7'h13;
  assign is_op    = opcode == 7'h33;

  assign pc_4  = pc + 32'd4;
  assign alu_b = is_op ? rv2 : imm_i;
  assign shamt = alu_b[4:0];
  assign sub   = is_op & inst[30];
  assign sra_y = $signed(rv1) >>> shamt;

  always_comb begin
    alu_y = 32'd0;
    unique case (f3)
      3'b000: alu_y = sub ? rv1 - alu_b : rv1 + alu_b;
      3'b001: alu_y = rv1 << shamt;
      3'b010: alu_y = {31'd0,
                       $signed(rv1) < $signed(alu_b)};
      3'b011: alu_y = {31'd0, rv1 < alu_b};
      3'b100: alu_y = rv1 ^ alu_b;
      3'b101: alu_y = inst[30] ? sra_y : rv1 >> shamt;
      3'b110: alu_y = rv1 | alu_b;
      3'b111: alu_y = rv1 & alu_b;
      default: alu_y = 32'd0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = rv1 == rv2;
      3'b001: taken = rv1 != rv2;
      3'b100: taken = $signed(rv1) < $signed(rv2);
      3'b101: taken = $signed(rv1) >= $signed(rv2);
      3'b110: taken = rv1 < rv2;
      3'b111: taken = rv1 >= rv2;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_4;
    unique case (1'b1)
      is_jal:          next_pc = pc + imm_j;
      is_jalr:         next_pc = (rv1 + imm_i) & ~32'd1;
      is_br && taken:  next_pc = pc + imm_b;
      default:         next_pc = pc_4;
    endcase
  end

  always_comb begin
    exec_we = 1'b1;
    exec_wd = alu_y;
    unique case (1'b1)
      is_lui:          exec_wd = imm_u;
      is_auipc:        exec_wd = pc + imm_u;
      is_jal, is_jalr: exec_wd = pc_4;
      is_op, is_opi:   exec_wd = alu_y;
      default:         exec_we = 1'b0;
    endcase
  end

  assign addr = rv1 + (is_st ? imm_s : imm_i);
  assign hit  = addr[31:28] == 4'h4;

  always_comb begin
    st_be = 4'b0000;
    st_d  = rv2;
    case (f3)
      3'b000: begin
        st_be = 4'b0001 << addr[1:0];
        st_d  = {4{rv2[7:0]}};
      end
      3'b001: begin
        st_be = addr[1] ? 4'b1100 : 4'b0011;
        st_d  = {2{rv2[15:0]}};
      end
      3'b010: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // Off-BIOS loads read as zero without touching the RAM.
  assign ld_w = ld_hit ? doutb : 32'd0;
  assign ld_h = ld_lo[1] ? ld_w[31:16] : ld_w[15:0];

  always_comb begin
    case (ld_lo)
      2'd0: ld_b = ld_w[7:0];
      2'd1: ld_b = ld_w[15:8];
      2'd2: ld_b = ld_w[23:16];
      default: ld_b = ld_w[31:24];
    endcase
  end

  always_comb begin
    case (f3)
      3'b000: ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001: ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100: ld_val = {24'd0, ld_b};
      3'b101: ld_val = {16'd0, ld_h};
      default: ld_val = ld_w;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ena     = 1'b0;
    enb     = 1'b0;
    web     = 4'b0000;
    rf_we   = 1'b0;
    rf_wd   = exec_wd;
    unique case (state)
      FETCH: begin
        ena     = 1'b1;
        state_n = EXEC;
      end
      EXEC: begin
        if (is_ld) begin
          enb     = hit;
          state_n = MEM;
        end else begin
          rf_we   = exec_we;
          pc_n    = next_pc;
          state_n = FETCH;
          if (is_st && hit && !rst) begin
            enb = 1'b1;
            web = st_be;
          end
        end
      end
      MEM: begin
        rf_we   = 1'b1;
        rf_wd   = ld_val;
        pc_n    = pc_4;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ld_lo  <= 2'd0;
      ld_hit <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state == EXEC && is_ld) begin
        ld_lo  <= addr[1:0];
        ld_hit <= hit;
      end
    end
  end
endmodule

// File: tb/tb_riscv151_core.sv
// Bench for riscv151_core: instruction-level reference model checked
// against the register file at every retirement, plus literal results.

module tb_riscv151_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  logic rst_q = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [31:0] mreg [0:31];
  logic [31:0] mmem [0:4095];
  logic [31:0] mpc;
  int cyc, due;
  logic [31:0] prog [$];

  riscv151_core dut (
    .clk            (clk),
    .rst            (rst),
    .FPGA_SERIAL_RX (rx),
    .FPGA_SERIAL_TX (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  function automatic logic [31:0] e_i(
    input logic [6:0] op, input logic [4:0] rd,
    input logic [2:0] f3, input logic [4:0] rs1,
    input int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(
    input logic [4:0] rd, input logic [4:0] rs1,
    input int imm);
    return e_i(7'h13, rd, 3'd0, rs1, imm);
  endfunction

  function automatic logic [31:0] e_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_s(
    input logic [2:0] f3, input logic [4:0] rs1,
    input logic [4:0] rs2, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:5], rs2, rs1, f3, m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(
    input logic [2:0] f3, input logic [4:0] rs1,
    input logic [4:0] rs2, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], rs2, rs1, f3,
            m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_u(
    input logic [6:0] op, input logic [4:0] rd,
    input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] e_j(
    input logic [4:0] rd, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], rd, 7'h6f};
  endfunction

  function automatic int lat(input logic [31:0] w);
    return (w[6:0] == 7'h03) ? 3 : 2;
  endfunction

  function automatic logic [31:0] m_alu(
    input logic [2:0] f3, input logic [31:0] x,
    input logic [31:0] y, input logic alt,
    input logic sb);
    logic [31:0] r;
    case (f3)
      3'd0: r = sb ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = ($signed(x) < $signed(y)) ? 1 : 0;
      3'd3: r = (x < y) ? 1 : 0;
      3'd4: r = x ^ y;
      3'd5: begin
        if (alt) r = $signed(x) >>> y[4:0];
        else r = x >> y[4:0];
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic logic m_br(
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij;
    logic [31:0] wv, npc, ad, w, bt, hf;
    logic [4:0] rd;
    logic [2:0] f3;
    logic wr;
    ins = mmem[mpc[13:2]];
    rd = ins[11:7];
    f3 = ins[14:12];
    a = mreg[ins[19:15]];
    b = mreg[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7],
          ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12],
          ins[20], ins[30:21], 1'b0};
    wv = 0;
    wr = 0;
    npc = mpc + 4;
    case (ins[6:0])
      7'h37: begin wv = iu; wr = 1; end
      7'h17: begin wv = mpc + iu; wr = 1; end
      7'h6f: begin wv = mpc + 4; wr = 1; npc = mpc + ij; end
      7'h67: begin
        wv = mpc + 4;
        wr = 1;
        npc = (a + ii) & 32'hFFFF_FFFE;
      end
      7'h63: if (m_br(f3, a, b)) npc = mpc + ib;
      7'h03: begin
        ad = a + ii;
        w = (ad[31:28] == 4'h4) ? mmem[ad[13:2]] : 0;
        bt = w >> (8 * ad[1:0]);
        hf = w >> (16 * ad[1]);
        wr = 1;
        case (f3)
          3'd0: wv = {{24{bt[7]}}, bt[7:0]};
          3'd1: wv = {{16{hf[15]}}, hf[15:0]};
          3'd4: wv = {24'h0, bt[7:0]};
          3'd5: wv = {16'h0, hf[15:0]};
          default: wv = w;
        endcase
      end
      7'h23: begin
        ad = a + is;
        if (ad[31:28] == 4'h4) begin
          case (f3)
            3'd0: mmem[ad[13:2]][8*ad[1:0] +: 8] = b[7:0];
            3'd1: mmem[ad[13:2]][16*ad[1] +: 16] = b[15:0];
            3'd2: mmem[ad[13:2]] = b;
            default: ;
          endcase
        end
      end
      7'h13: begin
        wv = m_alu(f3, a, ii, ins[30], 1'b0);
        wr = 1;
      end
      7'h33: begin
        wv = m_alu(f3, a, b, ins[30], ins[30]);
        wr = 1;
      end
      default: ;
    endcase
    if (wr && rd != 0) mreg[rd] = wv;
    mpc = npc;
  endtask

  task automatic cmp_regs(input string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < 32; i++) begin
      if (dut.rf.registers[i] !== mreg[i] && bad < 0) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s x%0d act=%h exp=%h model_pc=%h",
               tag, bad, dut.rf.registers[bad], mreg[bad], mpc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mpc = 32'h4000_0000;
        cyc = 0;
        due = lat(mmem[mpc[13:2]]);
        cmp_regs("reset_regs");
      end else begin
        cyc++;
        if (cyc == due) begin
          model_step();
          cmp_regs("retire");
          due = cyc + lat(mmem[mpc[13:2]]);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic load_prog();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      dut.bios_mem.mem[i] = 32'd0;
      mmem[i] = 32'd0;
    end
    for (int i = 0; i < prog.size(); i++) begin
      dut.bios_mem.mem[i] = prog[i];
      mmem[i] = prog[i];
    end
    repeat (2) @(negedge clk);
    chk("tx_in_reset", {31'd0, tx}, 32'd1);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = 32'd0;

    prog.delete();
    prog.push_back(addi(1, 0, 500));
    prog.push_back(addi(2, 0, 100));
    prog.push_back(e_i(7'h0f, 0, 0, 0, 0));
    prog.push_back(addi(20, 0, 1));
    prog.push_back(addi(0, 0, 5));
    prog.push_back(e_j(0, 0));
    load_prog();
    run(20);
    chk("alu_x1", dut.rf.registers[1], 32'd500);
    chk("alu_x2", dut.rf.registers[2], 32'd100);
    chk("alu_x20", dut.rf.registers[20], 32'd1);
    chk("x0_zero", dut.rf.registers[0], 32'd0);
    chk("tx_run", {31'd0, tx}, 32'd1);

    prog.delete();
    prog.push_back(addi(1, 0, 7));
    prog.push_back(addi(2, 0, 7));
    prog.push_back(e_b(3'd0, 1, 2, 8));
    prog.push_back(addi(1, 0, 999));
    prog.push_back(addi(1, 0, 500));
    prog.push_back(addi(2, 0, 100));
    prog.push_back(addi(20, 0, 2));
    prog.push_back(e_j(0, 0));
    load_prog();
    run(40);
    chk("beq_t_x20", dut.rf.registers[20], 32'd2);
    chk("beq_t_x1", dut.rf.registers[1], 32'd500);
    chk("beq_t_x2", dut.rf.registers[2], 32'd100);

    prog.delete();
    prog.push_back(addi(1, 0, 300));
    prog.push_back(addi(2, 0, 5));
    prog.push_back(e_b(3'd0, 1, 2, 8));
    prog.push_back(addi(2, 0, 111));
    prog.push_back(addi(20, 0, 3));
    prog.push_back(e_j(0, 0));
    load_prog();
    run(40);
    chk("beq_n_x20", dut.rf.registers[20], 32'd3);
    chk("beq_n_x2", dut.rf.registers[2], 32'd111);
    chk("beq_n_x1", dut.rf.registers[1], 32'd300);

    prog.delete();
    prog.push_back(addi(1, 0, -1));
    prog.push_back(addi(2, 0, 1));
    prog.push_back(e_b(3'd4, 2, 1, 8));
    prog.push_back(addi(10, 0, 1));
    prog.push_back(e_b(3'd6, 2, 1, 8));
    prog.push_back(addi(11, 0, 99));
    prog.push_back(e_r(7'h00, 1, 2, 3'd2, 12));
    prog.push_back(e_r(7'h00, 2, 1, 3'd3, 13));
    prog.push_back(e_b(3'd5, 2, 1, 8));
    prog.push_back(addi(14, 0, 99));
    prog.push_back(e_b(3'd7, 2, 1, 8));
    prog.push_back(addi(15, 0, 1));
    prog.push_back(e_r(7'h00, 2, 1, 3'd2, 16));
    prog.push_back(e_r(7'h00, 1, 2, 3'd3, 17));
    prog.push_back(e_j(0, 0));
    load_prog();
    run(60);
    chk("blt_not_taken", dut.rf.registers[10], 32'd1);
    chk("bltu_taken", dut.rf.registers[11], 32'd0);
    chk("slt_zero", dut.rf.registers[12], 32'd0);
    chk("sltu_zero", dut.rf.registers[13], 32'd0);
    chk("bge_taken", dut.rf.registers[14], 32'd0);
    chk("bgeu_not_taken", dut.rf.registers[15], 32'd1);
    chk("slt_one", dut.rf.registers[16], 32'd1);
    chk("sltu_one", dut.rf.registers[17], 32'd1);

    prog.delete();
    prog.push_back(e_u(7'h37, 6, 20'h40000));
    prog.push_back(e_u(7'h37, 1, 20'h80818));
    prog.push_back(addi(1, 1, 'h283));
    prog.push_back(addi(3, 0, 0));
    prog.push_back(e_j(5, 8));
    prog.push_back(addi(7, 0, 99));
    prog.push_back(e_s(3'd2, 6, 1, 'h400));
    prog.push_back(e_i(7'h03, 8, 3'd0, 6, 'h400));
    prog.push_back(e_i(7'h03, 9, 3'd4, 6, 'h400));
    prog.push_back(e_i(7'h03, 10, 3'd1, 6, 'h402));
    prog.push_back(e_i(7'h03, 11, 3'd5, 6, 'h400));
    prog.push_back(addi(2, 0, 'h7f));
    prog.push_back(e_s(3'd0, 6, 2, 'h401));
    prog.push_back(e_i(7'h03, 12, 3'd2, 6, 'h400));
    prog.push_back(addi(13, 0, 5));
    prog.push_back(e_i(7'h03, 13, 3'd2, 0, 0));
    prog.push_back(e_u(7'h17, 14, 20'h0));
    prog.push_back(e_i(7'h67, 15, 3'd0, 14, 9));
    prog.push_back(e_u(7'h17, 16, 20'h0));
    prog.push_back(e_i(7'h67, 16, 3'd0, 16, 12));
    prog.push_back(addi(17, 0, 99));
    prog.push_back(e_r(7'h20, 1, 0, 3'd0, 18));
    prog.push_back(e_i(7'h13, 19, 3'd5, 1, 'h404));
    prog.push_back(e_i(7'h13, 20, 3'd5, 1, 4));
    prog.push_back(e_i(7'h73, 21, 3'd1, 1, 'h51e));
    prog.push_back(e_j(0, 0));
    load_prog();
    run(120);
    chk("jal_link", dut.rf.registers[5], 32'h4000_0014);
    chk("jal_skip", dut.rf.registers[7], 32'd0);
    chk("lb", dut.rf.registers[8], 32'hFFFF_FF83);
    chk("lbu", dut.rf.registers[9], 32'h0000_0083);
    chk("lh_hi", dut.rf.registers[10], 32'hFFFF_8081);
    chk("lhu", dut.rf.registers[11], 32'h0000_8283);
    chk("lw_after_sb", dut.rf.registers[12], 32'h8081_7F83);
    chk("lw_offmap", dut.rf.registers[13], 32'd0);
    chk("auipc", dut.rf.registers[14], 32'h4000_0040);
    chk("jalr_link", dut.rf.registers[15], 32'h4000_0048);
    chk("jalr_rd_rs1", dut.rf.registers[16], 32'h4000_0050);
    chk("jalr_skip", dut.rf.registers[17], 32'd0);
    chk("sub", dut.rf.registers[18], 32'h7F7E_7D7D);
    chk("srai", dut.rf.registers[19], 32'hF808_1828);
    chk("srli", dut.rf.registers[20], 32'h0808_1828);
    chk("csr_nop", dut.rf.registers[21], 32'd0);
    chk("mem_word", dut.bios_mem.mem[256], 32'h8081_7F83);
    chk("model_mem", mmem[256], 32'h8081_7F83);
    chk("model_lb", mreg[8], 32'hFFFF_FF83);
    chk("model_jalr", mreg[16], 32'h4000_0050);

    prog.delete();
    prog.push_back(addi(1, 0, 0));
    prog.push_back(addi(1, 1, 1));
    prog.push_back(e_j(0, -4));
    load_prog();
    run(50);
    chk("loop_count", dut.rf.registers[1], 32'd12);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_x1", dut.rf.registers[1], 32'd0);
    rst = 1'b0;
    run(10);
    chk("restart_x1", dut.rf.registers[1], 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
